// File: rtl/pipeline_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pipeline_pkg : shared pipeline types, MEM-stage FSM encoding     |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
package pipeline_pkg;

  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } mem_state_e;

  function automatic logic is_access(input logic rd, input logic wr);
    return rd | wr;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_timeout_cnt.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_timeout_cnt : WAIT-cycle watchdog for mem_access_ctrl        |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module mem_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt;

  // expired flags the last permitted WAIT cycle, so the abort lands on its closing edge
  assign expired = en && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_access_ctrl : MEM-stage data-memory handshake and stall FSM  |
// | optional watchdog: MEM_TIMEOUT_EN                  rev 1.0       |
// +------------------------------------------------------------------+
module mem_access_ctrl
  import pipeline_pkg::*;
#(
  parameter int DATA_W         = DATA_W_DEF,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  input  logic [DATA_W-1:0] addr_in,
  input  logic [DATA_W-1:0] wdata_in,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              stall,
  output logic              wb_bubble,
  output logic [DATA_W-1:0] mem_data_out,
  output logic              busy,
  output logic              timeout_err
);

  mem_state_e state;
  logic       access_req;
  logic       timeout_hit;

  assign access_req = is_access(mem_read_in, mem_write_in);

  // Gated by reset_n so an abandoned access releases the pipeline immediately
  assign stall     = reset_n && (((state == IDLE) && access_req) || (state == WAIT));
  assign wb_bubble = stall;
  assign busy      = (state != IDLE);

`ifdef MEM_TIMEOUT_EN
  logic expired;
  logic err_q;

  mem_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (state != WAIT),
    .en      (state == WAIT),
    .expired (expired)
  );

  assign timeout_hit = expired;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q <= 1'b0;
    end else if ((state == WAIT) && !dmem_ack && expired) begin
      err_q <= 1'b1;
    end
  end

  assign timeout_err = err_q;
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout_param
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_wdata   <= '0;
      mem_data_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (access_req) begin
            state      <= WAIT;
            dmem_req   <= 1'b1;
            dmem_we    <= mem_write_in;
            dmem_addr  <= addr_in;
            dmem_wdata <= wdata_in;
          end
        end
        WAIT: begin
          // A late ack still wins over an expiring watchdog in the same cycle
          if (dmem_ack) begin
            if (!dmem_we) begin
              mem_data_out <= dmem_rdata;
            end
            dmem_req <= 1'b0;
            state    <= DONE;
          end else if (timeout_hit) begin
            mem_data_out <= '0;
            dmem_req     <= 1'b0;
            state        <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state    <= IDLE;
          dmem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_mem_access_ctrl : directed + randomized bench, reference model|
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_mem_access_ctrl;

  localparam int DW = 32;
  localparam int TO = 4;
`ifdef MEM_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          mem_read_in = 1'b0;
  logic          mem_write_in = 1'b0;
  logic [DW-1:0] addr_in = '0;
  logic [DW-1:0] wdata_in = '0;
  logic          dmem_ack = 1'b0;
  logic [DW-1:0] dmem_rdata = '0;
  logic          dmem_req, dmem_we, stall, wb_bubble, busy, timeout_err;
  logic [DW-1:0] dmem_addr, dmem_wdata, mem_data_out;

  always #5 clk = ~clk;

  mem_access_ctrl #(
    .DATA_W         (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .mem_read_in  (mem_read_in),
    .mem_write_in (mem_write_in),
    .addr_in      (addr_in),
    .wdata_in     (wdata_in),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_ack     (dmem_ack),
    .dmem_rdata   (dmem_rdata),
    .stall        (stall),
    .wb_bubble    (wb_bubble),
    .mem_data_out (mem_data_out),
    .busy         (busy),
    .timeout_err  (timeout_err)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: an access is either outstanding, just released, or absent
  bit            m_inflight = 0;
  bit            m_release  = 0;
  bit            m_req = 0, m_we = 0, m_err = 0;
  logic [DW-1:0] m_addr = '0, m_wdata = '0, m_data = '0;
  int            m_wcnt = 0;
  bit            cmp_en = 0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_inflight = 0; m_release = 0; m_req = 0; m_we = 0; m_err = 0;
      m_addr = '0; m_wdata = '0; m_data = '0; m_wcnt = 0;
    end else if (m_inflight) begin
      if (dmem_ack) begin
        if (!m_we) m_data = dmem_rdata;
        m_req = 0; m_inflight = 0; m_release = 1;
      end else begin
        m_wcnt++;
        if (TO_EN && m_wcnt == TO) begin
          m_req = 0; m_data = '0; m_err = 1; m_inflight = 0; m_release = 1;
        end
      end
    end else if (m_release) begin
      m_release = 0;
    end else if (mem_read_in || mem_write_in) begin
      m_inflight = 1; m_req = 1; m_we = mem_write_in;
      m_addr = addr_in; m_wdata = wdata_in; m_wcnt = 0;
    end
  end

  logic e_stall;
  always @(negedge clk) begin
    if (cmp_en) begin
      e_stall = reset_n && (m_inflight || (!m_release && (mem_read_in || mem_write_in)));
      chk("stall", 32'(stall), 32'(e_stall));
      chk("wb_bubble", 32'(wb_bubble), 32'(e_stall));
      chk("busy", 32'(busy), 32'(m_inflight || m_release));
      chk("dmem_req", 32'(dmem_req), 32'(m_req));
      chk("dmem_we", 32'(dmem_we), 32'(m_we));
      chk("dmem_addr", dmem_addr, m_addr);
      chk("dmem_wdata", dmem_wdata, m_wdata);
      chk("mem_data_out", mem_data_out, m_data);
      chk("timeout_err", 32'(timeout_err), 32'(m_err));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int scnt;

  initial begin
    repeat (3) @(posedge clk);
    cmp_en = 1;
    #1 reset_n = 1;
    @(negedge clk);
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_data", mem_data_out, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // load 0x10, ack in first WAIT cycle
    tick();
    mem_read_in = 1; addr_in = 32'h10;
    @(negedge clk);
    chk("ld_c0_stall", 32'(stall), 32'd1);
    chk("ld_c0_req", 32'(dmem_req), 32'd0);
    tick();
    dmem_ack = 1; dmem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("ld_c1_req", 32'(dmem_req), 32'd1);
    chk("ld_c1_addr", dmem_addr, 32'h10);
    chk("ld_c1_stall", 32'(stall), 32'd1);
    tick();
    dmem_ack = 0;
    @(negedge clk);
    chk("ld_done_stall", 32'(stall), 32'd0);
    chk("ld_done_data", mem_data_out, 32'hDEADBEEF);
    chk("ld_done_req", 32'(dmem_req), 32'd0);
    chk("ld_done_busy", 32'(busy), 32'd1);
    tick();
    mem_read_in = 0;
    @(negedge clk);
    chk("ld_idle_busy", 32'(busy), 32'd0);

    // store 0x1234 to 0x20, ack in 5th WAIT cycle
    tick();
    mem_write_in = 1; addr_in = 32'h20; wdata_in = 32'h1234;
    scnt = 0;
    @(negedge clk);
    if (stall) scnt++;
    for (int i = 1; i <= 5; i++) begin
      tick();
      addr_in = 32'h99; wdata_in = 32'h77;
      dmem_ack = (i == 5); dmem_rdata = 32'hBAD0BAD0;
      @(negedge clk);
      chk("st_we", 32'(dmem_we), 32'd1);
      chk("st_addr", dmem_addr, 32'h20);
      chk("st_wdata", dmem_wdata, 32'h1234);
      if (stall) scnt++;
    end
    tick();
    dmem_ack = 0;
    @(negedge clk);
    chk("st_done_stall", 32'(stall), 32'd0);
    chk("st_data_kept", mem_data_out, 32'hDEADBEEF);
    chk("st_stall_cycles", 32'(scnt), 32'd6);
    tick();
    mem_write_in = 0;

    // two back-to-back loads
    tick();
    mem_read_in = 1; addr_in = 32'h30; dmem_ack = 1; dmem_rdata = 32'h11112222;
    @(negedge clk);
    chk("b2b_c0_stall", 32'(stall), 32'd1);
    tick();
    @(negedge clk);
    chk("b2b_w1_req", 32'(dmem_req), 32'd1);
    tick();
    dmem_ack = 0; addr_in = 32'h34;
    @(negedge clk);
    chk("b2b_done1_data", mem_data_out, 32'h11112222);
    chk("b2b_done1_req", 32'(dmem_req), 32'd0);
    tick();
    @(negedge clk);
    chk("b2b_idle_stall", 32'(stall), 32'd1);
    chk("b2b_idle_req", 32'(dmem_req), 32'd0);
    tick();
    @(negedge clk);
    chk("b2b_req2_rise", 32'(dmem_req), 32'd1);
    chk("b2b_addr2", dmem_addr, 32'h34);
    dmem_ack = 1; dmem_rdata = 32'h55AA55AA;
    tick();
    dmem_ack = 0; mem_read_in = 0;
    @(negedge clk);
    chk("b2b_done2_data", mem_data_out, 32'h55AA55AA);
    tick();

    // spurious ack while idle
    dmem_ack = 1; dmem_rdata = 32'hCAFEF00D;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("spur_busy", 32'(busy), 32'd0);
      chk("spur_data", mem_data_out, 32'h55AA55AA);
      tick();
    end
    dmem_ack = 0;

    // reset in the 3rd WAIT cycle
    mem_read_in = 1; addr_in = 32'h40;
    tick(); tick(); tick();
    reset_n = 0;
    @(negedge clk);
    chk("rstw_req", 32'(dmem_req), 32'd0);
    chk("rstw_stall", 32'(stall), 32'd0);
    tick();
    reset_n = 1; mem_read_in = 0;
    @(negedge clk);
    chk("rstw_idle_busy", 32'(busy), 32'd0);
    chk("rstw_data", mem_data_out, 32'd0);
    tick();

`ifdef MEM_TIMEOUT_EN
    mem_read_in = 1; addr_in = 32'h50; dmem_ack = 0;
    for (int w = 1; w <= 4; w++) begin
      tick();
      @(negedge clk);
      chk("to_wait_req", 32'(dmem_req), 32'd1);
    end
    tick();
    @(negedge clk);
    chk("to_req_drop", 32'(dmem_req), 32'd0);
    chk("to_err", 32'(timeout_err), 32'd1);
    chk("to_data", mem_data_out, 32'd0);
    tick();
    mem_read_in = 0;
    repeat (3) tick();
    @(negedge clk);
    chk("to_err_sticky", 32'(timeout_err), 32'd1);
    tick();
`endif

    // randomized traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      mem_read_in  = ($urandom % 4) == 0;
      mem_write_in = ($urandom % 5) == 0;
      addr_in      = $urandom;
      wdata_in     = $urandom;
      dmem_ack     = ($urandom % 3) == 0;
      dmem_rdata   = $urandom;
      if (!reset_n) reset_n = 1;
      else if (($urandom % 250) == 0) reset_n = 0;
      tick();
    end
    reset_n = 1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning the width of address, write data and read data.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 16, meaning the maximum WAIT cycles before abort; used only with MEM_TIMEOUT_EN.
REQ-003 SHALL have ports:
- clk  in  1  clock; single clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- mem_read_in  in  1  MEM-stage load request.
- mem_write_in  in  1  MEM-stage store request.
- addr_in  in  DATA_W  MEM-stage address (ALU result).
- wdata_in  in  DATA_W  store data.
- dmem_req  out  1  data-memory request, registered.
- dmem_we  out  1  data-memory write enable, registered.
- dmem_addr  out  DATA_W  latched address.
- dmem_wdata  out  DATA_W  latched store data.
- dmem_ack  in  1  data-memory completion.
- dmem_rdata  in  DATA_W  read data, valid when dmem_ack=1.
- stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM.
- wb_bubble  out  1  force reg_write=0 into the MEM/WB register.
- mem_data_out  out  DATA_W  load data for the MEM/WB register.
- busy  out  1  state is not IDLE.
- timeout_err  out  1  sticky abort flag.

Function
REQ-004 SHALL implement the FSM states IDLE, WAIT and DONE.
REQ-005 SHALL, in IDLE with mem_read_in|mem_write_in=1: assert stall combinationally in that cycle, register dmem_req=1, dmem_we=mem_write_in, dmem_addr=addr_in and dmem_wdata=wdata_in, and move to WAIT.
REQ-006 SHALL, in IDLE with no access: keep stall=0 and dmem_req=0, and stay in IDLE.
REQ-007 SHALL, in WAIT: hold stall=1, and hold dmem_req, dmem_we, dmem_addr and dmem_wdata stable until dmem_ack is sampled high.
REQ-008 SHALL, on dmem_ack=1 in WAIT: load dmem_rdata into mem_data_out if the access is a read, and leave mem_data_out unchanged if it is a write; clear dmem_req on the next edge; move to DONE.
REQ-009 SHALL, in DONE: drive stall=0 for exactly one cycle so that the pipeline advances and MEM/WB samples mem_data_out, then move to IDLE unconditionally.
REQ-010 SHALL keep the minimum latency at 2 stall cycles, with the access seen in cycle 0, dmem_req high in cycle 1 and ack in cycle 1, and stall low in cycle 2.
REQ-011 SHALL drive wb_bubble equal to stall, so that a frozen instruction never writes back twice.
REQ-012 SHALL ignore dmem_ack in IDLE and in DONE, with no state or data change.
REQ-013 SHALL treat mem_read_in and mem_write_in both high as a write, with no read-data capture.
REQ-014 SHALL drive busy=1 in WAIT and in DONE.
REQ-015 SHALL, for back-to-back accesses, start a new access in the IDLE cycle that follows DONE, with no lost request.

Reset
REQ-016 SHALL, while reset_n=0, asynchronously force: state=IDLE; dmem_req, dmem_we, dmem_addr, dmem_wdata, mem_data_out and timeout_err all 0; the timeout counter 0.
REQ-017 SHALL, on reset in mid-WAIT, abandon the access with dmem_req=0 immediately, and resume in IDLE after the first edge following reset_n going high.

Configuration
REQ-018 SHALL, with MEM_TIMEOUT_EN defined, count WAIT cycles and, on reaching TIMEOUT_CYCLES without ack: clear dmem_req, set mem_data_out=0, set timeout_err=1 until reset, and move to DONE.
REQ-019 SHALL, with MEM_TIMEOUT_EN undefined, wait indefinitely in WAIT, tie timeout_err to 0, and contain no counter logic.

Structure
REQ-020 SHALL take the FSM state encodings (IDLE=2'd0, WAIT=2'd1, DONE=2'd2) and the default DATA_W from the shared package pipeline_pkg.
REQ-021 SHALL, when MEM_TIMEOUT_EN is defined, place the watchdog in one sub-module mem_timeout_cnt (ports clr, en, expired); the remainder SHALL be a single module.

Verification
REQ-022 SHALL cover: load to 0x10, ack in 1st WAIT cycle with rdata=0xDEADBEEF -> stall high for exactly 2 cycles, mem_data_out=0xDEADBEEF in the DONE cycle.
REQ-023 SHALL cover: store of 0x1234 to 0x20, ack after 5 cycles -> dmem_we=1, dmem_addr/dmem_wdata stable for all 5 cycles, stall for 6 cycles, mem_data_out unchanged.
REQ-024 SHALL cover: two loads back-to-back -> the second dmem_req rises exactly 2 cycles after the first DONE, and wb_bubble equals stall throughout.
REQ-025 SHALL cover: spurious dmem_ack in IDLE -> no state change and mem_data_out unchanged.
REQ-026 SHALL cover: reset_n pulled low in the 3rd WAIT cycle -> dmem_req=0 and stall=0 in the same cycle, IDLE after release.
REQ-027 SHALL cover, with MEM_TIMEOUT_EN and TIMEOUT_CYCLES=4: no ack -> dmem_req drops after 4 WAIT cycles, timeout_err=1 and stays 1, mem_data_out=0.
